cpu_run_ctrl: RTL and testbench

// Synthesizable run controller that sits between the board clock/reset and the processor top.
// - Stretches the board reset into a fixed-length processor reset.
// - Produces a divided clock-enable for the processor.
// - Supports run, halt, single-step and run-to-cycle-count modes.
// - Keeps a saturating count of executed processor cycles.

---
 rtl/cpu_run_pkg.sv | 25 ++
 rtl/cpu_run_ctrl_clk_en_div.sv | 29 ++
 rtl/cpu_run_ctrl.sv | 133 +++++++++++++
 tb/tb_cpu_run_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_run_pkg.sv
// Shared encodings for the processor run controller: FSM states and run modes.
package cpu_run_pkg;

    // Controller FSM states (also exported on the State debug port).
    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2,
        ST_STEP  = 2'd3
    } run_state_t;

    // Run-mode selector driven by the debugger/host.
    typedef enum logic [1:0] {
        MODE_RUN          = 2'b00,
        MODE_HALT         = 2'b01,
        MODE_STEP         = 2'b10,
        MODE_RUN_TO_COUNT = 2'b11
    } run_mode_t;

    // HALT and STEP both park the processor; only the step edge differs.
    function automatic logic mode_parks(input run_mode_t mode);
        return (mode == MODE_HALT) || (mode == MODE_STEP);
    endfunction

endpackage

// File: rtl/cpu_run_ctrl_clk_en_div.sv
// Clock-enable divider: Tick is high once every Div+1 cycles.
// The counter wraps on Tick and also whenever it finds itself above a
// freshly lowered Div, so a divisor change never stalls the enable.
module clk_en_div #(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Clr,
    input  logic [DIV_WIDTH-1:0] Div,
    output logic                 Tick
);

    logic [DIV_WIDTH-1:0] divcnt_reg;

    assign Tick = (divcnt_reg == Div);

    // Free-running divide counter, held at zero while Clr is asserted.
    always_ff @(posedge Clk) begin
        if (Rst || Clr) begin
            divcnt_reg <= '0;
        end else if (divcnt_reg >= Div) begin
            divcnt_reg <= '0;
        end else begin
            divcnt_reg <= divcnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller between board clock/reset and the processor: stretches
// reset, issues divided clock-enables, implements run/halt/step/run-to-count
// and keeps a saturating count of issued enables.
module cpu_run_ctrl
    import cpu_run_pkg::*;
#(
    parameter int RST_CYCLES = 4,
    parameter int DIV_WIDTH  = 8,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [1:0]           Mode,
    input  logic                 StepReq,
    input  logic [DIV_WIDTH-1:0] Div,
    input  logic [CNT_WIDTH-1:0] StopCount,
    output logic                 CpuRst,
    output logic                 CpuEn,
    output logic [CNT_WIDTH-1:0] CycleCount,
    output logic                 Halted,
    output logic [1:0]           State
);

    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);

    run_state_t           state_reg, state_next;
    logic [RW-1:0]        rst_cnt_reg, rst_cnt_next;
    logic                 cpu_rst_reg, cpu_rst_next;
    logic                 cpu_en_reg, en_next;
    logic [CNT_WIDTH-1:0] count_reg, count_next, count_inc;
    logic                 halted_reg;
    logic                 step_q_reg;
    logic                 step_edge;
    logic                 tick;
    logic                 parks;
    logic                 to_count;
    run_mode_t            mode;

    assign mode      = run_mode_t'(Mode);
    assign parks     = mode_parks(mode);
    assign to_count  = (mode == MODE_RUN_TO_COUNT);
    assign step_edge = StepReq & ~step_q_reg;
    assign count_inc = (count_reg == {CNT_WIDTH{1'b1}}) ? count_reg : count_reg + 1'b1;

    clk_en_div #(
        .DIV_WIDTH(DIV_WIDTH)
    ) u_div (
        .Clk (Clk),
        .Rst (Rst),
        .Clr (state_reg == ST_RESET),
        .Div (Div),
        .Tick(tick)
    );

    // Next-state, enable and reset-stretch decisions for the run FSM.
    always_comb begin
        state_next   = state_reg;
        rst_cnt_next = rst_cnt_reg;
        cpu_rst_next = 1'b0;
        en_next      = 1'b0;
        case (state_reg)
            ST_RESET: begin
                cpu_rst_next = 1'b1;
                if (rst_cnt_reg == RST_LAST) begin
                    cpu_rst_next = 1'b0;
                    state_next   = parks ? ST_HALT : ST_RUN;
                end else begin
                    rst_cnt_next = rst_cnt_reg + 1'b1;
                end
            end
            ST_RUN: begin
                if (parks || (to_count && (count_reg >= StopCount))) begin
                    state_next = ST_HALT;
                end else begin
                    en_next = tick;
                    // The enable that reaches the target is the last one.
                    if (to_count && tick && (count_inc >= StopCount)) begin
                        state_next = ST_HALT;
                    end
                end
            end
            ST_HALT: begin
                if (mode == MODE_RUN) begin
                    state_next = ST_RUN;
                end else if (to_count && (count_reg < StopCount)) begin
                    state_next = ST_RUN;
                end else if ((mode == MODE_STEP) && step_edge) begin
                    state_next = ST_STEP;
                end
            end
            ST_STEP: begin
                // Further step edges are ignored until this step completes.
                if (tick) begin
                    en_next    = 1'b1;
                    state_next = ST_HALT;
                end
            end
            default: begin
                state_next = ST_RESET;
            end
        endcase
        count_next = en_next ? count_inc : count_reg;
    end

    // Registered state and outputs; Rst overrides everything.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_reg   <= ST_RESET;
            rst_cnt_reg <= '0;
            cpu_rst_reg <= 1'b1;
            cpu_en_reg  <= 1'b0;
            count_reg   <= '0;
            halted_reg  <= 1'b0;
            step_q_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            rst_cnt_reg <= rst_cnt_next;
            cpu_rst_reg <= cpu_rst_next;
            cpu_en_reg  <= en_next;
            count_reg   <= count_next;
            halted_reg  <= (state_next == ST_HALT);
            step_q_reg  <= StepReq;
        end
    end

    assign CpuRst     = cpu_rst_reg;
    assign CpuEn      = cpu_en_reg;
    assign CycleCount = count_reg;
    assign Halted     = halted_reg;
    assign State      = state_reg;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: directed scenarios followed by random
// traffic, compared every cycle against a behavioural model. A second
// instance with a 4-bit counter exercises saturation under the same stimulus.
module tb_cpu_run_ctrl;
    import cpu_run_pkg::*;

    localparam int RST_CYCLES = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  mode = 2'b00;
    logic        step_req = 1'b0;
    logic [7:0]  div = 8'd0;
    logic [31:0] stop_count = 32'd0;

    logic        cpu_rst0, cpu_en0, halted0;
    logic [31:0] count0;
    logic [1:0]  state0;
    logic        cpu_rst1, cpu_en1, halted1;
    logic [3:0]  count1;
    logic [1:0]  state1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu_run_ctrl #(.RST_CYCLES(RST_CYCLES), .DIV_WIDTH(8), .CNT_WIDTH(32)) dut (
        .Clk(clk), .Rst(rst), .Mode(mode), .StepReq(step_req), .Div(div),
        .StopCount(stop_count), .CpuRst(cpu_rst0), .CpuEn(cpu_en0),
        .CycleCount(count0), .Halted(halted0), .State(state0)
    );

    cpu_run_ctrl #(.RST_CYCLES(RST_CYCLES), .DIV_WIDTH(8), .CNT_WIDTH(4)) dut4 (
        .Clk(clk), .Rst(rst), .Mode(mode), .StepReq(step_req), .Div(div),
        .StopCount(stop_count[3:0]), .CpuRst(cpu_rst1), .CpuEn(cpu_en1),
        .CycleCount(count1), .Halted(halted1), .State(state1)
    );

    // Behavioural model, one slot per instance.
    run_state_t m_phase [2];
    int         m_wait  [2];
    int         m_div   [2];
    longint     m_count [2];
    bit         m_en    [2];
    bit         m_cpurst[2];
    bit         m_prev;
    longint     m_max   [2] = '{64'h0000_0000_FFFF_FFFF, 64'd15};

    function automatic longint sat_inc(input longint c, input longint mx);
        return (c >= mx) ? mx : c + 1;
    endfunction

    task automatic model_edge();
        bit step_edge;
        step_edge = step_req && !m_prev;
        m_prev    = rst ? 1'b0 : step_req;
        for (int d = 0; d < 2; d++) begin
            longint stop;
            bit     tick;
            bit     parks;
            bit     rtc;
            stop = (d == 0) ? longint'(stop_count) : longint'(stop_count & 32'hF);
            if (rst) begin
                m_phase[d] = ST_RESET; m_wait[d] = 0; m_div[d] = 0;
                m_count[d] = 0; m_en[d] = 1'b0; m_cpurst[d] = 1'b1;
                continue;
            end
            tick = (m_div[d] == int'(div));
            if (m_phase[d] == ST_RESET) m_div[d] = 0;
            else m_div[d] = (m_div[d] >= int'(div)) ? 0 : m_div[d] + 1;
            parks   = (mode == 2'b01) || (mode == 2'b10);
            rtc     = (mode == 2'b11);
            m_en[d] = 1'b0;
            case (m_phase[d])
                ST_RESET: begin
                    m_wait[d]++;
                    if (m_wait[d] == RST_CYCLES) begin
                        m_cpurst[d] = 1'b0;
                        m_phase[d]  = parks ? ST_HALT : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (parks || (rtc && m_count[d] >= stop)) begin
                        m_phase[d] = ST_HALT;
                    end else if (tick) begin
                        m_en[d]    = 1'b1;
                        m_count[d] = sat_inc(m_count[d], m_max[d]);
                        if (rtc && m_count[d] >= stop) m_phase[d] = ST_HALT;
                    end
                end
                ST_HALT: begin
                    if (mode == 2'b00) m_phase[d] = ST_RUN;
                    else if (rtc && m_count[d] < stop) m_phase[d] = ST_RUN;
                    else if (mode == 2'b10 && step_edge) m_phase[d] = ST_STEP;
                end
                default: begin
                    if (tick) begin
                        m_en[d]    = 1'b1;
                        m_count[d] = sat_inc(m_count[d], m_max[d]);
                        m_phase[d] = ST_HALT;
                    end
                end
            endcase
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: advance model at the edge, compare just after it.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check("cpu_rst", 64'(cpu_rst0), 64'(m_cpurst[0]));
        check("cpu_en", 64'(cpu_en0), 64'(m_en[0]));
        check("cycle_count", 64'(count0), 64'(m_count[0]));
        check("halted", 64'(halted0), 64'(m_phase[0] == ST_HALT));
        check("state", 64'(state0), 64'(m_phase[0]));
        check("cpu_en_w4", 64'(cpu_en1), 64'(m_en[1]));
        check("cycle_count_w4", 64'(count1), 64'(m_count[1]));
        check("state_w4", 64'(state1), 64'(m_phase[1]));
    endtask

    initial begin
        int pulses;

        // 1: reset stretch, then enable every cycle.
        rst = 1'b1; mode = 2'b00; div = 8'd0;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < RST_CYCLES - 1; i++) begin
            cycle();
            check("rst_stretch", 64'(cpu_rst0), 64'd1);
        end
        cycle();
        check("rst_release", 64'(cpu_rst0), 64'd0);
        repeat (10) cycle();

        // 2: divide by four.
        div = 8'd3;
        repeat (40) cycle();

        // 3: single step with StepReq held high.
        rst = 1'b1; div = 8'd0;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 100 && m_count[0] < 5; i++) cycle();
        mode = 2'b10;
        cycle();
        step_req = 1'b1;
        repeat (10) cycle();
        step_req = 1'b0;
        repeat (4) cycle();
        check("step_count", 64'(count0), 64'd6);
        check("step_halted", 64'(halted0), 64'd1);

        // 4: run to count 20 with Div=1.
        rst = 1'b1;
        cycle();
        rst = 1'b0; mode = 2'b11; stop_count = 32'd20; div = 8'd1;
        pulses = 0;
        for (int i = 0; i < 70; i++) begin
            cycle();
            if (cpu_en0) pulses++;
        end
        check("rtc_pulses", 64'(pulses), 64'd20);
        check("rtc_count", 64'(count0), 64'd20);
        check("rtc_halted", 64'(halted0), 64'd1);

        // 5: reset in the middle of a run.
        rst = 1'b1; mode = 2'b00; div = 8'd0;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 100 && m_count[0] < 7; i++) cycle();
        check("mid_count", 64'(count0), 64'd7);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("mid_rst_cpurst", 64'(cpu_rst0), 64'd1);
        check("mid_rst_en", 64'(cpu_en0), 64'd0);
        check("mid_rst_count", 64'(count0), 64'd0);
        check("mid_rst_state", 64'(state0), 64'(ST_RESET));

        // 6: saturation of the 4-bit instance.
        repeat (30) cycle();
        check("sat_count", 64'(count1), 64'd15);
        check("sat_en", 64'(cpu_en1), 64'd1);

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) step_req = ~step_req;
            if ($urandom_range(0, 31) == 0) div = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 31) == 0) stop_count = 32'($urandom_range(0, 40));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
